// File: rtl/perf_pkg.sv
//------------------------------------------------------------------------------
// perf_pkg
// Shared sizing, counter index map and reader FSM state type for the
// performance-counter reader.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package perf_pkg;

    localparam int NUM_CTR = 8;
    localparam int OUT_W   = 32;
    localparam int CTR_W   = 2 * OUT_W;

    localparam int CTR_CYCLE      = 0;
    localparam int CTR_INSTR      = 1;
    localparam int CTR_MEM        = 2;
    localparam int CTR_BP_MISS    = 3;
    localparam int CTR_CACHE_MISS = 4;
    localparam int CTR_STALL      = 5;
    localparam int CTR_FLUSH      = 6;
    localparam int CTR_BRANCH     = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } perf_rd_state_t;

endpackage

`default_nettype wire

// File: rtl/perf_snap_bank.sv
//------------------------------------------------------------------------------
// perf_snap_bank
// Capture registers for the counter snapshot plus a 32-bit word-select mux.
// Build option PERF_DELTA_EN: capture the per-counter delta since the
// previous snapshot instead of the absolute value.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module perf_snap_bank #(
    parameter int NUM_CTR = perf_pkg::NUM_CTR,
    parameter int CTR_W   = perf_pkg::CTR_W,
    parameter int OUT_W   = perf_pkg::OUT_W,
    parameter int IDX_W   = $clog2(2 * NUM_CTR)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     capture,
    input  logic [NUM_CTR*CTR_W-1:0] ctr_flat,
    input  logic [IDX_W-1:0]         word_idx,
    output logic [OUT_W-1:0]         word_data
);

    logic [NUM_CTR-1:0][CTR_W-1:0] r_snap;
    logic [CTR_W-1:0]              w_ctr_sel;

`ifdef PERF_DELTA_EN
    logic [NUM_CTR-1:0][CTR_W-1:0] r_prev_snap;

    // Subtraction wraps modulo 2^CTR_W so a counter that went backwards
    // reports the wrapped difference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap      <= '0;
            r_prev_snap <= '0;
        end else if (capture) begin
            for (int k = 0; k < NUM_CTR; k++) begin
                r_snap[k]      <= ctr_flat[k*CTR_W +: CTR_W] - r_prev_snap[k];
                r_prev_snap[k] <= ctr_flat[k*CTR_W +: CTR_W];
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap <= '0;
        end else if (capture) begin
            for (int k = 0; k < NUM_CTR; k++) begin
                r_snap[k] <= ctr_flat[k*CTR_W +: CTR_W];
            end
        end
    end
`endif

    // Upper index bits pick the counter, bit 0 picks the half.
    assign w_ctr_sel = r_snap[word_idx[IDX_W-1:1]];
    assign word_data = word_idx[0] ? w_ctr_sel[CTR_W-1:OUT_W] : w_ctr_sel[OUT_W-1:0];

endmodule

`default_nettype wire

// File: rtl/perf_counter_reader.sv
//------------------------------------------------------------------------------
// perf_counter_reader
// Takes an atomic snapshot of all event counters on request and streams it
// out as low/high 32-bit words over valid/ready. Build option PERF_DELTA_EN
// streams per-counter deltas since the previous snapshot.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module perf_counter_reader #(
    parameter int NUM_CTR = perf_pkg::NUM_CTR,
    parameter int CTR_W   = perf_pkg::CTR_W,
    parameter int OUT_W   = perf_pkg::OUT_W,
    parameter int IDX_W   = $clog2(2 * NUM_CTR)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CTR*CTR_W-1:0] ctr_flat,
    input  logic                     snap_req,
    output logic                     snap_busy,
    output logic                     snap_drop,
    output logic                     snap_done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_last
);

    import perf_pkg::*;

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(2 * NUM_CTR - 1);
    localparam logic [IDX_W-1:0] c_IDX_ONE  = IDX_W'(1);

    perf_rd_state_t   r_state;
    perf_rd_state_t   w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             r_drop;
    logic             w_capture;
    logic             w_valid;
    logic             w_done;
    logic             w_last;
    logic [OUT_W-1:0] w_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_drop  <= snap_req && (r_state != IDLE);
        end
    end

    // out_valid is decoded from state only, so out_ready never reaches it
    // combinationally.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_capture   = 1'b0;
        w_valid     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (snap_req) begin
                    w_capture   = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                w_valid = 1'b1;
                if (out_ready) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_idx_nxt = r_idx + c_IDX_ONE;
                    end
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    perf_snap_bank #(
        .NUM_CTR (NUM_CTR),
        .CTR_W   (CTR_W),
        .OUT_W   (OUT_W),
        .IDX_W   (IDX_W)
    ) u_snap_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture   (w_capture),
        .ctr_flat  (ctr_flat),
        .word_idx  (r_idx),
        .word_data (w_word)
    );

    assign w_last    = w_valid && (r_idx == c_LAST_IDX);
    assign snap_busy = (r_state != IDLE);
    assign snap_drop = r_drop;
    assign snap_done = w_done;
    assign out_valid = w_valid;
    assign out_data  = w_valid ? w_word : '0;
    assign out_idx   = w_valid ? r_idx : '0;
    assign out_last  = w_last;

endmodule

`default_nettype wire

// File: doc/perf_counter_reader.md
Name: perf_counter_reader

Overview:
- Consumer side of the performance-counter block: takes a coherent snapshot of all 64-bit event counters on request, then streams them out as 32-bit words over a valid/ready interface.
- Sits between the counter bank and the debug/trace uplink (or a CSR bridge), so software reads a single atomic sample instead of tearing across live counters.

Parameters:
- NUM_CTR, 8, number of 64-bit counters in the flat input bus (cycle, instr, mem, bp_miss, cache_miss, stall, flush, branch).
- CTR_W, 64, counter width; fixed at 2*OUT_W.
- OUT_W, 32, stream word width.
- IDX_W, $clog2(2*NUM_CTR), word-index width (4 at defaults).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- ctr_flat  input  NUM_CTR*CTR_W  live counters; counter k at bits [k*CTR_W +: CTR_W].
- snap_req  input  1  single-cycle snapshot request.
- snap_busy  output  1  high while a snapshot is held or streaming.
- snap_drop  output  1  one-cycle pulse when snap_req arrives while busy.
- snap_done  output  1  one-cycle pulse in the cycle after the final word handshake.
- out_valid  output  1  stream word valid.
- out_ready  input  1  downstream ready.
- out_data  output  OUT_W  stream word.
- out_idx  output  IDX_W  word index; even = low half, odd = high half of counter idx>>1.
- out_last  output  1  high with the final word (idx = 2*NUM_CTR-1).

Behaviour:
- Reset values: all outputs 0, state IDLE, snapshot registers 0, index 0. Reset is asynchronous: mid-stream assertion drops out_valid immediately and discards the snapshot.
- FSM states are IDLE, SEND, DONE.
- IDLE:
  - snap_busy=0, out_valid=0.
  - snap_req=1 → snapshot regs <= ctr_flat on that edge; index <= 0; go to SEND.
- SEND:
  - out_valid=1; out_data = snapshot[idx>>1] low word if idx even, high word if idx odd.
  - Handshake occurs on out_valid && out_ready.
  - On handshake with idx < 2*NUM_CTR-1: idx increments.
  - On handshake with out_last: go to DONE.
- DONE:
  - snap_done=1 for exactly one cycle, then IDLE.
  - snap_busy stays 1 in DONE.
- Latency: snap_req sampled at edge N gives out_valid=1 from cycle N+1. Minimum 2*NUM_CTR cycles with out_ready held high; full sequence from request to IDLE is 2*NUM_CTR+2 cycles.
- Stream rules:
  - out_data, out_idx and out_last are held stable while out_valid && !out_ready.
  - out_valid never deasserts in SEND without a handshake.
  - No combinational path from out_ready to out_valid.
- snap_req while snap_busy=1 (SEND or DONE): ignored; snap_drop pulses the next cycle; the snapshot is unaffected.
- Live ctr_flat changes after capture never affect streamed data (atomicity).
- Arithmetic: plain register copy, no saturation; index compare uses IDX_W bits; no wrap beyond the last word.

Optional Feature:
- Macro: PERF_DELTA_EN.
- When defined:
  - A prev_snap register bank (NUM_CTR*CTR_W, reset 0) is added.
  - At capture: snapshot <= ctr_flat - prev_snap (per counter, modulo 2^64) and prev_snap <= ctr_flat.
  - The first snapshot after reset therefore equals the absolute values.
  - A counter that decreases (e.g. counters reset) yields the wrapped modulo-2^64 difference; no flagging.
- When undefined: absolute values are streamed and there is no prev_snap storage.

Decomposition:
- Shared package perf_pkg:
  - localparams NUM_CTR, CTR_W, OUT_W.
  - counter index constants CTR_CYCLE=0 … CTR_BRANCH=7.
  - enum type perf_rd_state_t {IDLE, SEND, DONE}.
- Sub-module: perf_snap_bank, which holds the capture registers (and the delta logic under PERF_DELTA_EN) and provides a word-select read mux. The FSM and handshake stay in the top.

Test Plan:
- Basic stream:
  - Stimulus: ctr_flat counter k = 64'h0000_000k_1000_000k; pulse snap_req; out_ready=1.
  - Required: 16 words 0x1000_0000,0x0000_0000, 0x1000_0001,0x0000_0001, …; idx 0..15; out_last only on word 15; snap_done the cycle after; snap_busy back to 0.
- Backpressure:
  - Stimulus: toggle out_ready randomly, holding it low for 3 cycles on word 5.
  - Required: out_data/out_idx stable while stalled; no word lost or duplicated; order unchanged.
- Atomicity:
  - Stimulus: increment every counter each cycle after capture.
  - Required: streamed values equal the values at the capture edge (e.g. cycle counter captured at 100 streams 100, not 116).
- Drop:
  - Stimulus: snap_req during SEND word 3, and again during DONE.
  - Required: snap_drop pulses for each request; the stream completes unchanged; no second stream starts.
- Reset mid-stream:
  - Stimulus: deassert rst_n at word 7.
  - Required: out_valid=0 immediately and all outputs 0; a fresh snap_req after release streams new values from idx 0.
- PERF_DELTA_EN:
  - Stimulus: first snapshot with cycle counter=50, second with cycle counter=80; then a third with a counter reduced from 80 to 10.
  - Required: streamed values 50, then 30; the third yields 0xFFFF_FFFF_FFFF_FFBA.
